pe_mac_cfg: RTL and testbench

PE_MAC_CFG -- requirements
Module: pe_mac_cfg

---
 rtl/pe_mac_cfg.sv | 116 +++++++++++
 tb/tb_pe_mac_cfg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_cfg.sv
// pe_mac_cfg: systolic multiply-accumulate processing element with
// configurable signedness, accumulator width and saturation.
module pe_mac_cfg #(
    parameter int AW   = 8,
    parameter int BW   = 8,
    parameter int ACCW = 32,
    parameter int SAT  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic [AW-1:0]   a_in,
    input  logic [BW-1:0]   b_in,
    input  logic            vld_in,
    input  logic            first_in,
    input  logic            last_in,
    input  logic            sgn_mode,
    output logic [AW-1:0]   a_out,
    output logic [BW-1:0]   b_out,
    output logic            vld_out,
    output logic            first_out,
    output logic            last_out,
    output logic            sgn_out,
    output logic [ACCW-1:0] res_out,
    output logic            res_vld,
    output logic            res_ovf
);
    localparam int PW = AW + BW + 1;

    if (ACCW < PW) begin : g_accw_check
        $error("pe_mac_cfg: ACCW must be at least AW+BW+1");
    end

    logic signed [PW-1:0] ax, bx, prod, p2;
    logic                 v2, f2, l2, s2;
    logic [ACCW-1:0]      acc, sat_val, acc_nxt;
    logic                 ovf, act, ovf_now, ovf_nxt, take;
    logic signed [ACCW:0] pe, base, sum;

    // Operand extension, one-bit-headroom accumulate and overflow/clamp selection.
    // Products always fit in PW bits, so multiplying PW-wide extended operands
    // and keeping the low PW bits yields the exact product.
    always_comb begin
        ax      = {{(PW-AW){sgn_out & a_out[AW-1]}}, a_out};
        bx      = {{(PW-BW){sgn_out & b_out[BW-1]}}, b_out};
        prod    = ax * bx;
        pe      = {{(ACCW+1-PW){p2[PW-1]}}, p2};
        base    = f2 ? '0 : (s2 ? {acc[ACCW-1], acc} : {1'b0, acc});
        sum     = base + pe;
        ovf_now = s2 ? (sum[ACCW] ^ sum[ACCW-1]) : sum[ACCW];
        sat_val = s2 ? {sum[ACCW], {(ACCW-1){~sum[ACCW]}}} : '1;
        acc_nxt = (ovf_now && SAT != 0) ? sat_val : sum[ACCW-1:0];
        ovf_nxt = (ovf & ~f2) | ovf_now;
        take    = v2 & (f2 | act);
    end

    // Stage 1: systolic pass-through registers; flags only count on valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out     <= '0;
            b_out     <= '0;
            vld_out   <= 1'b0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
            sgn_out   <= 1'b0;
        end else if (ce) begin
            a_out     <= a_in;
            b_out     <= b_in;
            vld_out   <= vld_in;
            first_out <= first_in & vld_in;
            last_out  <= last_in & vld_in;
            sgn_out   <= sgn_mode;
        end
    end

    // Stage 2: registered product with its beat tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2 <= '0;
            v2 <= 1'b0;
            f2 <= 1'b0;
            l2 <= 1'b0;
            s2 <= 1'b0;
        end else if (ce) begin
            p2 <= prod;
            v2 <= vld_out;
            f2 <= first_out;
            l2 <= last_out;
            s2 <= sgn_out;
        end
    end

    // Stage 3: accumulate while a sequence is open; beats outside a sequence
    // (e.g. the tail of one cut by reset) are dropped until the next first beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf     <= 1'b0;
            act     <= 1'b0;
            res_out <= '0;
            res_vld <= 1'b0;
            res_ovf <= 1'b0;
        end else if (ce) begin
            res_vld <= take & l2;
            if (take) begin
                acc <= acc_nxt;
                ovf <= ovf_nxt;
                act <= ~l2;
            end
            if (take & l2) begin
                res_out <= acc_nxt;
                res_ovf <= ovf_nxt;
            end
        end
    end
endmodule

// File: tb/tb_pe_mac_cfg.sv
// tb_pe_mac_cfg: scoreboard bench driving three pe_mac_cfg configurations
// (32-bit wrap, 17-bit saturate, 17-bit wrap) with the same beat stream.
module tb_pe_mac_cfg;
    logic       clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic       vld_in = 1'b0, first_in = 1'b0, last_in = 1'b0, sgn_mode = 1'b0;

    logic [7:0]  a_o [3];
    logic [7:0]  b_o [3];
    logic [2:0]  vo, fo, lo, so, rv, ro;
    logic [31:0] r0;
    logic [16:0] r1, r2;

    typedef struct packed {
        logic [31:0] v0;
        logic [16:0] v1;
        logic [16:0] v2;
        logic [2:0]  o;
    } exp_t;

    exp_t   q[$];
    int     total = 0, bad = 0;
    longint sum [3];
    bit     ovfm [3];
    bit     act = 1'b0;
    int     accw [3] = '{32, 17, 17};
    bit     satc [3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    pe_mac_cfg d0 (.clk(clk), .rst_n(rst_n), .ce(ce), .a_in(a_in), .b_in(b_in), .vld_in(vld_in),
        .first_in(first_in), .last_in(last_in), .sgn_mode(sgn_mode), .a_out(a_o[0]), .b_out(b_o[0]),
        .vld_out(vo[0]), .first_out(fo[0]), .last_out(lo[0]), .sgn_out(so[0]), .res_out(r0),
        .res_vld(rv[0]), .res_ovf(ro[0]));
    pe_mac_cfg #(.ACCW(17), .SAT(1)) d1 (.clk(clk), .rst_n(rst_n), .ce(ce), .a_in(a_in), .b_in(b_in),
        .vld_in(vld_in), .first_in(first_in), .last_in(last_in), .sgn_mode(sgn_mode), .a_out(a_o[1]),
        .b_out(b_o[1]), .vld_out(vo[1]), .first_out(fo[1]), .last_out(lo[1]), .sgn_out(so[1]),
        .res_out(r1), .res_vld(rv[1]), .res_ovf(ro[1]));
    pe_mac_cfg #(.ACCW(17), .SAT(0)) d2 (.clk(clk), .rst_n(rst_n), .ce(ce), .a_in(a_in), .b_in(b_in),
        .vld_in(vld_in), .first_in(first_in), .last_in(last_in), .sgn_mode(sgn_mode), .a_out(a_o[2]),
        .b_out(b_o[2]), .vld_out(vo[2]), .first_out(fo[2]), .last_out(lo[2]), .sgn_out(so[2]),
        .res_out(r2), .res_vld(rv[2]), .res_ovf(ro[2]));

    function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endfunction

    function automatic logic [127:0] snap_f();
        return {36'd0, a_o[0], b_o[0], vo[0], fo[0], lo[0], so[0], r0, r1, r2, rv, ro};
    endfunction

    // Sequence-level reference: true sums with range clamp or modular wrap.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input bit f, input bit l, input bit s);
        longint p, m, hi, lo_b;
        exp_t   e;
        p = s ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
        if (!f && !act) return;
        for (int k = 0; k < 3; k++) begin
            m    = 64'sd1 <<< accw[k];
            hi   = s ? m / 2 - 1 : m - 1;
            lo_b = s ? -(m / 2) : 0;
            if (f) begin
                sum[k]  = p;
                ovfm[k] = 1'b0;
            end else begin
                sum[k] = sum[k] + p;
                if (sum[k] > hi) begin
                    ovfm[k] = 1'b1;
                    sum[k]  = satc[k] ? hi : sum[k] - m;
                end else if (sum[k] < lo_b) begin
                    ovfm[k] = 1'b1;
                    sum[k]  = satc[k] ? lo_b : sum[k] + m;
                end
            end
        end
        act = !l;
        if (l) begin
            e.v0 = sum[0][31:0];
            e.v1 = sum[1][16:0];
            e.v2 = sum[2][16:0];
            e.o  = {ovfm[2], ovfm[1], ovfm[0]};
            q.push_back(e);
        end
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input bit v, input bit f,
                         input bit l, input bit s, input bit c);
        @(negedge clk);
        a_in = a; b_in = b; vld_in = v; first_in = f; last_in = l; sgn_mode = s; ce = c;
        if (c && v) model(a, b, f, l, s);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'($urandom), 8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    function automatic logic [7:0] pick();
        int r = $urandom_range(0, 7);
        return r == 0 ? 8'd0 : r == 1 ? 8'd127 : r == 2 ? 8'd128 : r == 3 ? 8'd255 : 8'($urandom);
    endfunction

    // Monitor: pass-through, stall freeze, and scoreboard pops on ce-qualified results.
    initial begin
        logic [127:0] cur, prev;
        logic [20:0]  pt_exp;
        bit           ces, have;
        exp_t         e;
        have = 1'b0;
        pt_exp = '0;
        forever begin
            @(posedge clk);
            ces = ce;
            if (ce && rst_n) pt_exp = {a_in, b_in, vld_in, first_in & vld_in, last_in & vld_in, sgn_mode};
            #1;
            cur = snap_f();
            if (rst_n) begin
                if (!ces && have) chk("stall_freeze", cur, prev);
                if (ces) chk("passthru", {a_o[0], b_o[0], vo[0], fo[0], lo[0], so[0]}, pt_exp);
                if (ces && rv[0]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("res_acc32", r0, e.v0);
                        chk("res_acc17_sat", r1, e.v1);
                        chk("res_acc17_wrap", r2, e.v2);
                        chk("res_ovf", ro, e.o);
                        chk("res_vld_all", rv, 3'b111);
                    end
                end
            end
            prev = cur;
            have = rst_n;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_zero", snap_f(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ce = 1'b1;
        // Signed three-beat sequence with exact latency check
        drive(8'd3, 8'd4, 1, 1, 0, 1, 1);
        drive(8'hFE, 8'd5, 1, 0, 0, 1, 1);
        drive(8'd7, 8'hFF, 1, 0, 1, 1, 1);
        @(posedge clk); #1 chk("lat_edge_t", rv[0], 0);
        idle(1);
        @(posedge clk); #1 chk("lat_edge_t1", rv[0], 0);
        idle(1);
        @(posedge clk); #1;
        chk("lat_edge_t2", rv[0], 1);
        chk("res_minus5", r0, 32'hFFFF_FFFB);
        chk("ovf_minus5", ro[0], 0);
        idle(1);
        @(posedge clk); #1 chk("lat_edge_t3", rv[0], 0);
        idle(2);
        // Single beats: unsigned 255*255 and signed (-1)*(-1)
        drive(8'd255, 8'd255, 1, 1, 1, 0, 1);
        drive(8'd255, 8'd255, 1, 1, 1, 1, 1);
        idle(4);
        // Five signed (127,127) beats overflow the 17-bit accumulators
        for (int i = 0; i < 5; i++) drive(8'd127, 8'd127, 1, i == 0, i == 4, 1, 1);
        // Three unsigned (255,255) beats overflow unsigned 17-bit
        for (int i = 0; i < 3; i++) drive(8'd255, 8'd255, 1, i == 0, i == 2, 0, 1);
        // Signed negative overflow: (-128)*(127) repeated
        for (int i = 0; i < 6; i++) drive(8'd128, 8'd127, 1, i == 0, i == 5, 1, 1);
        // Back-to-back sequences: 5 then 9
        drive(8'd1, 8'd1, 1, 1, 0, 0, 1);
        drive(8'd2, 8'd2, 1, 0, 1, 0, 1);
        drive(8'd3, 8'd3, 1, 1, 1, 0, 1);
        idle(4);
        // Randomized sequences with gaps, stalls and occasional abandoned sequences
        for (int n = 0; n < 90; n++) begin
            bit s, ab;
            int len;
            s   = 1'($urandom);
            len = $urandom_range(1, 6);
            ab  = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0)
                    drive(8'($urandom), 8'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                if ($urandom_range(0, 4) == 0)
                    drive(pick(), pick(), 1, 1'($urandom), 1'($urandom), 1'($urandom), 0);
                drive(pick(), pick(), 1, i == 0, (i == len - 1) && !ab, s, 1);
            end
        end
        idle(6);
        // Reset in the middle of a sequence, then its tail without a first beat
        drive(8'd5, 8'd6, 1, 1, 0, 1, 1);
        drive(8'd7, 8'd8, 1, 0, 0, 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        act = 1'b0;
        #1 chk("reset_async_zero", snap_f(), 0);
        repeat (2) @(negedge clk);
        chk("reset_hold_zero", snap_f(), 0);
        rst_n = 1'b1;
        drive(8'd9, 8'd9, 1, 0, 0, 1, 1);
        drive(8'd2, 8'd2, 1, 0, 1, 1, 1);
        idle(5);
        drive(8'd10, 8'd20, 1, 1, 0, 0, 1);
        drive(8'd30, 8'd3, 1, 0, 1, 0, 1);
        idle(6);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
